// File: rtl/regfile_write_buffer.sv
// In-order write buffer in front of the single write port of the 16x20 register file.
// Define BYPASS_EN to enable newest-pending-value lookup for the two decode read addresses.
module regfile_write_buffer #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [ADDR_W-1:0]          wb_reg,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       drain_hold,
  output logic [ADDR_W-1:0]          rf_write_reg,
  output logic [DATA_W-1:0]          rf_write_data,
  output logic                       rf_reg_write,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic [ADDR_W-1:0]          rd_addr1,
  input  logic [ADDR_W-1:0]          rd_addr2,
  output logic                       byp_hit1,
  output logic                       byp_hit2,
  output logic [DATA_W-1:0]          byp_data1,
  output logic [DATA_W-1:0]          byp_data2
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] reg_idx;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign wb_ready = (count < CNT_W'(DEPTH));
  assign push     = wb_valid && wb_ready;
  assign pop      = (count != '0) && !drain_hold;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      rf_reg_write  <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr        <= ptr_inc(rd_ptr);
        rf_write_reg  <= mem[rd_ptr].reg_idx;
        rf_write_data <= mem[rd_ptr].data;
        rf_reg_write  <= 1'b1;
      end else begin
        rf_reg_write  <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; occupancy (count/pointers) alone decides which slots are live.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{reg_idx: wb_reg, data: wb_data};
  end

`ifdef BYPASS_EN
  // Scan oldest to newest so a newer match overrides an older one; the rf_* stage is lowest priority.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    logic [PTR_W-1:0] idx;
    byp_hit1  = 1'b0;
    byp_hit2  = 1'b0;
    byp_data1 = '0;
    byp_data2 = '0;
    idx       = rd_ptr;
    if (rf_reg_write && (rf_write_reg == rd_addr1)) begin
      byp_hit1  = 1'b1;
      byp_data1 = rf_write_data;
    end
    if (rf_reg_write && (rf_write_reg == rd_addr2)) begin
      byp_hit2  = 1'b1;
      byp_data2 = rf_write_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count) begin
        if (mem[idx].reg_idx == rd_addr1) begin
          byp_hit1  = 1'b1;
          byp_data1 = mem[idx].data;
        end
        if (mem[idx].reg_idx == rd_addr2) begin
          byp_hit2  = 1'b1;
          byp_data2 = mem[idx].data;
        end
      end
      idx = ptr_inc(idx);
    end
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr1, rd_addr2};
  assign byp_hit1  = 1'b0;
  assign byp_hit2  = 1'b0;
  assign byp_data1 = '0;
  assign byp_data2 = '0;
`endif

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Scoreboard bench for regfile_write_buffer: accepted writes are queued and matched
// against every cycle that rf_reg_write is raised; scenario tasks add inline checks.
module tb_regfile_write_buffer;

`ifdef BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_reg;
  logic [19:0] wb_data;
  logic        drain_hold;
  logic [3:0]  rf_write_reg;
  logic [19:0] rf_write_data;
  logic        rf_reg_write;
  logic [2:0]  count;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic        byp_hit1;
  logic        byp_hit2;
  logic [19:0] byp_data1;
  logic [19:0] byp_data2;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] exp_q [$];
  logic [19:0] rf_model [16];

  regfile_write_buffer #(.DATA_W(20), .ADDR_W(4), .DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
    .drain_hold(drain_hold),
    .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data), .rf_reg_write(rf_reg_write),
    .count(count),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data1(byp_data1), .byp_data2(byp_data2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file model: captures on the falling edge.
  always @(negedge clock) begin
    if (rf_reg_write) rf_model[rf_write_reg] = rf_write_data;
  end

  // Scoreboard consumer: every issued write must match the oldest accepted request.
  always @(posedge clock) begin
    logic [23:0] exp;
    #1;
    if (reset_n && rf_reg_write) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got reg=%0d data=%h, expected no write", rf_write_reg, rf_write_data);
      end else begin
        exp = exp_q.pop_front();
        if ({rf_write_reg, rf_write_data} !== exp) begin
          n_fail++;
          $display("FAIL write_order: got reg=%0d data=%h, expected reg=%0d data=%h",
                   rf_write_reg, rf_write_data, exp[23:20], exp[19:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // One clock cycle: inputs are applied at the falling edge, accept decided from wb_ready.
  task automatic step(input logic v, input logic [3:0] r, input logic [19:0] d, input logic h);
    logic acc;
    wb_valid   = v;
    wb_reg     = r;
    wb_data    = d;
    drain_hold = h;
    acc        = v && wb_ready;
    @(posedge clock);
    if (acc) exp_q.push_back({r, d});
    @(negedge clock);
  endtask

  task automatic check_cleared(input string tag);
    n_checks++;
    if ({count, wb_ready, rf_reg_write, rf_write_reg, rf_write_data} !== {3'd0, 1'b1, 1'b0, 4'd0, 20'd0}) begin
      n_fail++;
      $display("FAIL %s: got count=%0d ready=%b we=%b reg=%0d data=%h, expected 0,1,0,0,00000",
               tag, count, wb_ready, rf_reg_write, rf_write_reg, rf_write_data);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    reset_n = 1'b1;
    check_cleared("reset_state");
  endtask

  task automatic test_single_write;
    step(1, 4'd3, 20'h00ABC, 0);
    n_checks++;
    if (rf_reg_write !== 1'b0 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL single_latency_k: got we=%b count=%0d, expected we=0 count=1", rf_reg_write, count);
    end
    step(0, 0, 0, 0);
    n_checks++;
    if ({rf_reg_write, rf_write_reg, rf_write_data} !== {1'b1, 4'd3, 20'h00ABC}) begin
      n_fail++;
      $display("FAIL single_issue: got we=%b reg=%0d data=%h, expected 1,3,00abc",
               rf_reg_write, rf_write_reg, rf_write_data);
    end
    #1;
    n_checks++;
    if (rf_model[3] !== 20'h00ABC) begin
      n_fail++;
      $display("FAIL rf_capture_r3: got %h, expected 00abc", rf_model[3]);
    end
    step(0, 0, 0, 0);
    n_checks++;
    if (rf_reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL single_one_cycle: got we=%b, expected 0", rf_reg_write);
    end
  endtask

  task automatic test_full_hold;
    for (int i = 1; i <= 4; i++) step(1, 4'(i), 20'(i), 1);
    n_checks++;
    if (count !== 3'd4 || wb_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_state: got count=%0d ready=%b, expected 4,0", count, wb_ready);
    end
    step(1, 4'd7, 20'h7, 1);
    n_checks++;
    if (count !== 3'd4 || rf_reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL full_push_ignored: got count=%0d we=%b, expected 4,0", count, rf_reg_write);
    end
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 0);
      n_checks++;
      if (rf_reg_write !== 1'b1 || rf_write_reg !== 4'(i)) begin
        n_fail++;
        $display("FAIL drain_cycle%0d: got we=%b reg=%0d, expected 1,%0d", i, rf_reg_write, rf_write_reg, i);
      end
    end
    n_checks++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL drain_empty: got count=%0d, expected 0", count);
    end
    step(0, 0, 0, 1);
    n_checks++;
    if (rf_reg_write !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL hold_when_empty: got we=%b count=%0d, expected 0,0", rf_reg_write, count);
    end
  endtask

  task automatic check_bypass(input string tag, input logic eh1, input logic [19:0] ed1);
    #1;
    n_checks++;
    if ({byp_hit1, byp_data1, byp_hit2, byp_data2} !== {eh1, ed1, 1'b0, 20'd0}) begin
      n_fail++;
      $display("FAIL %s: got hit1=%b data1=%h hit2=%b data2=%h, expected %b,%h,0,00000",
               tag, byp_hit1, byp_data1, byp_hit2, byp_data2, eh1, ed1);
    end
  endtask

  task automatic test_bypass;
    rd_addr1 = 4'd5;
    rd_addr2 = 4'd6;
    step(1, 4'd5, 20'h1, 1);
    step(1, 4'd5, 20'h2, 1);
    check_bypass("byp_newest_fifo", BYP, BYP ? 20'h2 : 20'h0);
    step(0, 0, 0, 0);
    check_bypass("byp_fifo_over_rf", BYP, BYP ? 20'h2 : 20'h0);
    step(0, 0, 0, 0);
    check_bypass("byp_rf_stage", BYP, BYP ? 20'h2 : 20'h0);
    step(0, 0, 0, 0);
    check_bypass("byp_none", 1'b0, 20'h0);
  endtask

  task automatic test_back_to_back;
    step(1, 4'd8, 20'h11, 1);
    step(1, 4'd9, 20'h22, 1);
    for (int i = 0; i < 6; i++) begin
      step(1, 4'(10 + i), 20'h30 + 20'(i), 0);
      n_checks++;
      if (count !== 3'd2 || rf_reg_write !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got count=%0d we=%b, expected 2,1", i, count, rf_reg_write);
      end
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    n_checks++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_drain: got count=%0d, expected 0", count);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) step(1, 4'(12 + i), 20'hABCDE, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_cleared("reset_mid_async");
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      n_checks++;
      if (rf_reg_write !== 1'b0 || count !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_no_stale%0d: got we=%b count=%0d, expected 0,0", i, rf_reg_write, count);
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    wb_valid   = 1'b0;
    wb_reg     = '0;
    wb_data    = '0;
    drain_hold = 1'b0;
    rd_addr1   = '0;
    rd_addr2   = '0;
    foreach (rf_model[i]) rf_model[i] = '0;
    @(negedge clock);
    test_reset();
    test_single_write();
    test_full_hold();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
